corevx_loadunit: RTL and testbench

- Sequential load-access stage between execute and the combinational load data generator.
- Accepts one load request, classifies it (misaligned or unknown type) before any bus traffic, and issues a word-aligned read on the data-memory bus.
- Captures the returned word and presents the raw word, in-word offset, load type and destination register to the downstream extender with a valid/ready handshake.
- Reports faults alongside the response.

---
 rtl/corevx_loadunit_if.sv | 45 ++++
 rtl/corevx_loadunit.sv | 169 ++++++++++++++++
 tb/tb_corevx_loadunit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corevx_loadunit_if.sv
// Load-unit bundle: request side from execute, data-memory read bus, and the
// response side towards the load data extender.
interface corevx_loadunit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_rd;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic        m_readdatavalid;
  logic [31:0] m_readdata;
  logic [1:0]  m_response;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_offset;
  logic [2:0]  rsp_type;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;

  // Load-unit view: it masters the memory bus and drives the response.
  modport master (
    input  req_valid, req_addr, req_type, req_rd,
    output req_ready,
    output m_address, m_read,
    input  m_waitrequest, m_readdatavalid, m_readdata, m_response,
    output rsp_valid, rsp_data, rsp_offset, rsp_type, rsp_rd, rsp_fault, rsp_cause,
    input  rsp_ready
  );

  // Environment view: execute stage, memory slave and extender together.
  modport slave (
    output req_valid, req_addr, req_type, req_rd,
    input  req_ready,
    input  m_address, m_read,
    output m_waitrequest, m_readdatavalid, m_readdata, m_response,
    input  rsp_valid, rsp_data, rsp_offset, rsp_type, rsp_rd, rsp_fault, rsp_cause,
    output rsp_ready
  );
endinterface

// File: rtl/corevx_loadunit.sv
// Sequential load-access stage: classifies a load, issues one word-aligned bus
// read, captures the raw word and hands it to the extender with a fault code.
module corevx_loadunit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  corevx_loadunit_if.master   bus
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseMisalgn = 2'b01;
  localparam logic [1:0] CauseUnknown = 2'b10;
  localparam logic [1:0] CauseAccess  = 2'b11;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StResp} state_e;

  state_e      r_state, w_state_d;
  logic        r_m_read, w_m_read_d;
  logic [31:0] r_m_address, w_m_address_d;
  logic        r_rsp_valid, w_rsp_valid_d;
  logic [31:0] r_rsp_data, w_rsp_data_d;
  logic [1:0]  r_rsp_offset, w_rsp_offset_d;
  logic [2:0]  r_rsp_type, w_rsp_type_d;
  logic [4:0]  r_rsp_rd, w_rsp_rd_d;
  logic [1:0]  r_rsp_cause, w_rsp_cause_d;
  logic [15:0] r_cnt, w_cnt_d;
  // A flush seen while the bus still stalls must survive until the read is taken.
  logic        r_flush_pend, w_flush_pend_d;

  logic w_accept;
  logic w_known;
  logic w_misaligned;

  assign w_accept = bus.req_valid && (r_state == StIdle) && !flush;
  assign w_known  = bus.req_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_misaligned = ((bus.req_type == 3'b010) && (bus.req_addr[1:0] != 2'b00)) ||
                        (((bus.req_type == 3'b001) || (bus.req_type == 3'b101)) &&
                         bus.req_addr[0]);

  // Next-state and next-register decode for the whole stage.
  always_comb begin
    w_state_d      = r_state;
    w_m_read_d     = r_m_read;
    w_m_address_d  = r_m_address;
    w_rsp_valid_d  = r_rsp_valid;
    w_rsp_data_d   = r_rsp_data;
    w_rsp_offset_d = r_rsp_offset;
    w_rsp_type_d   = r_rsp_type;
    w_rsp_rd_d     = r_rsp_rd;
    w_rsp_cause_d  = r_rsp_cause;
    w_cnt_d        = r_cnt;
    w_flush_pend_d = r_flush_pend;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_rsp_offset_d = bus.req_addr[1:0];
          w_rsp_type_d   = bus.req_type;
          w_rsp_rd_d     = bus.req_rd;
          w_rsp_data_d   = '0;
          w_rsp_cause_d  = CauseNone;
          w_flush_pend_d = 1'b0;
          if (!w_known) begin
            w_rsp_cause_d = CauseUnknown;
            w_rsp_valid_d = 1'b1;
            w_state_d     = StResp;
          end else if (w_misaligned) begin
            w_rsp_cause_d = CauseMisalgn;
            w_rsp_valid_d = 1'b1;
            w_state_d     = StResp;
          end else begin
            w_m_address_d = {bus.req_addr[31:2], 2'b00};
            w_m_read_d    = 1'b1;
            w_state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        if (flush) begin
          w_flush_pend_d = 1'b1;
        end
        if (!bus.m_waitrequest) begin
          w_m_read_d = 1'b0;
          w_cnt_d    = '0;
          w_state_d  = (flush || r_flush_pend) ? StDrain : StWait;
        end
      end
      StWait: begin
        if (flush) begin
          // Keep counting so the drain deadline matches the original one.
          w_cnt_d   = r_cnt + 16'd1;
          w_state_d = StDrain;
        end else if (bus.m_readdatavalid) begin
          w_rsp_data_d  = bus.m_readdata;
          w_rsp_cause_d = (bus.m_response != 2'b00) ? CauseAccess : CauseNone;
          w_rsp_valid_d = 1'b1;
          w_state_d     = StResp;
        end else if (r_cnt >= CntLast) begin
          w_rsp_cause_d = CauseAccess;
          w_rsp_valid_d = 1'b1;
          w_state_d     = StResp;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StDrain: begin
        if (bus.m_readdatavalid || (r_cnt >= CntLast)) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StResp: begin
        if (flush || bus.rsp_ready) begin
          w_rsp_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_m_read     <= 1'b0;
      r_m_address  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_offset <= '0;
      r_rsp_type   <= '0;
      r_rsp_rd     <= '0;
      r_rsp_cause  <= CauseNone;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_m_read     <= w_m_read_d;
      r_m_address  <= w_m_address_d;
      r_rsp_valid  <= w_rsp_valid_d;
      r_rsp_data   <= w_rsp_data_d;
      r_rsp_offset <= w_rsp_offset_d;
      r_rsp_type   <= w_rsp_type_d;
      r_rsp_rd     <= w_rsp_rd_d;
      r_rsp_cause  <= w_rsp_cause_d;
      r_cnt        <= w_cnt_d;
      r_flush_pend <= w_flush_pend_d;
    end
  end

  assign bus.req_ready  = (r_state == StIdle);
  assign bus.m_read     = r_m_read;
  assign bus.m_address  = r_m_address;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_offset = r_rsp_offset;
  assign bus.rsp_type   = r_rsp_type;
  assign bus.rsp_rd     = r_rsp_rd;
  assign bus.rsp_cause  = r_rsp_cause;
  assign bus.rsp_fault  = (r_rsp_cause != CauseNone);

endmodule

// File: tb/tb_corevx_loadunit.sv
// Bench for corevx_loadunit: transaction-level timeline model plus a per-cycle
// compare process; a second instance with a short timeout covers timeouts.
module tb_corevx_loadunit;

  logic clk;
  logic rst_n;
  logic sel4;
  logic chk_en;
  int   cyc;
  int   total;
  int   bad;

  // Driven inputs, shared by both instances.
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic [2:0]  d_req_type;
  logic [4:0]  d_req_rd;
  logic        d_flush;
  logic        d_waitreq;
  logic        d_rdv;
  logic [31:0] d_rdata;
  logic [1:0]  d_resp;
  logic        d_rsp_ready;

  corevx_loadunit_if u_if0 ();
  corevx_loadunit_if u_if4 ();

  assign u_if0.req_valid       = d_req_valid & ~sel4;
  assign u_if4.req_valid       = d_req_valid & sel4;
  assign u_if0.req_addr        = d_req_addr;
  assign u_if4.req_addr        = d_req_addr;
  assign u_if0.req_type        = d_req_type;
  assign u_if4.req_type        = d_req_type;
  assign u_if0.req_rd          = d_req_rd;
  assign u_if4.req_rd          = d_req_rd;
  assign u_if0.m_waitrequest   = d_waitreq;
  assign u_if4.m_waitrequest   = d_waitreq;
  assign u_if0.m_readdatavalid = d_rdv;
  assign u_if4.m_readdatavalid = d_rdv;
  assign u_if0.m_readdata      = d_rdata;
  assign u_if4.m_readdata      = d_rdata;
  assign u_if0.m_response      = d_resp;
  assign u_if4.m_response      = d_resp;
  assign u_if0.rsp_ready       = d_rsp_ready;
  assign u_if4.rsp_ready       = d_rsp_ready;

  corevx_loadunit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (d_flush),
    .bus   (u_if0.master)
  );

  corevx_loadunit #(
    .TIMEOUT_CYCLES (4)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (d_flush),
    .bus   (u_if4.master)
  );

  // Observed outputs of the selected instance; payload is
  // {data[31:0], offset[1:0], type[2:0], rd[4:0], fault, cause[1:0]}.
  logic        o_req_ready;
  logic        o_m_read;
  logic [31:0] o_m_address;
  logic        o_rsp_valid;
  logic [44:0] o_pay;

  assign o_req_ready = sel4 ? u_if4.req_ready : u_if0.req_ready;
  assign o_m_read    = sel4 ? u_if4.m_read : u_if0.m_read;
  assign o_m_address = sel4 ? u_if4.m_address : u_if0.m_address;
  assign o_rsp_valid = sel4 ? u_if4.rsp_valid : u_if0.rsp_valid;
  assign o_pay = sel4 ?
    {u_if4.rsp_data, u_if4.rsp_offset, u_if4.rsp_type, u_if4.rsp_rd, u_if4.rsp_fault,
     u_if4.rsp_cause} :
    {u_if0.rsp_data, u_if0.rsp_offset, u_if0.rsp_type, u_if0.rsp_rd, u_if0.rsp_fault,
     u_if0.rsp_cause};

  // Current transaction timeline published by the driver.
  int          t_a, t_b, t_r, t_rend, t_idle;
  bit          t_bus, t_rsp;
  logic [31:0] t_waddr;
  logic [44:0] t_pay;

  // Observations used by the hand-computed checks.
  int          obs_rsp_first;
  logic [44:0] obs_pay;
  logic [31:0] obs_addr;
  bit          obs_mread_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want finish by 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    t_a = -100; t_b = -100; t_r = -100; t_rend = -100; t_idle = -100;
    t_bus = 1'b0; t_rsp = 1'b0; t_waddr = '0; t_pay = '0;
  endtask

  // Compare every cycle against the published timeline.
  initial begin
    int  c;
    bit  em, ev, er;
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        c  = cyc;
        em = t_bus && (c >= t_a + 1) && (c <= t_b);
        chk("m_read", 64'(o_m_read), 64'(em));
        if (o_m_read && em) chk("m_address", 64'(o_m_address), 64'(t_waddr));
        ev = t_rsp && (c >= t_r) && (c <= t_rend);
        chk("rsp_valid", 64'(o_rsp_valid), 64'(ev));
        if (o_rsp_valid && ev) chk("rsp_payload", 64'(o_pay), 64'(t_pay));
        er = !((c >= t_a + 1) && (c < t_idle));
        chk("req_ready", 64'(o_req_ready), 64'(er));
        if (o_m_read) begin
          obs_mread_seen = 1'b1;
          obs_addr = o_m_address;
        end
        if (o_rsp_valid && obs_rsp_first < 0) begin
          obs_rsp_first = c;
          obs_pay = o_pay;
        end
      end
    end
  end

  // One load: the model derives the full timeline from the stimulus knobs,
  // then the driver plays the bus/consumer side cycle by cycle.
  // ws: stall cycles; dd: data delay after the bus takes the read; rw: consumer
  // delay; fmode 1/2/3: flush in ISSUE/WAIT/RESP at offset fcyc.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] typ,
                          input logic [4:0] rd, input int ws, input int dd,
                          input logic [31:0] data, input logic [1:0] resp,
                          input int rw, input int fmode_in, input int fcyc);
    int to, a, b, r, rend, idle, last, fmode, guard;
    bit unk, mis, busld;
    logic [1:0] cause;
    logic [31:0] edata;
    to = sel4 ? 4 : 255;
    guard = 0;
    @(posedge clk); #1;
    while (!o_req_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_load", 64'(o_req_ready), 64'd1);
    unk   = !(typ inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = !unk && (((typ == 3'd2) && (addr[1:0] != 2'd0)) ||
                     (((typ == 3'd1) || (typ == 3'd5)) && addr[0]));
    busld = !unk && !mis;
    fmode = (!busld && fmode_in != 3) ? 0 : fmode_in;
    a = cyc;
    b = a + 1 + ws;
    r = -100;
    rend = -100;
    cause = 2'd0;
    edata = '0;
    idle = a + 1;
    if (!busld) begin
      r = a + 1;
      cause = unk ? 2'd2 : 2'd1;
    end else if (fmode == 1 || fmode == 2) begin
      idle = (dd <= to) ? b + dd + 1 : b + to + 1;
    end else if (dd <= to) begin
      r = b + 1 + dd;
      cause = (resp != 2'd0) ? 2'd3 : 2'd0;
      edata = data;
    end else begin
      r = b + 1 + to;
      cause = 2'd3;
    end
    if (r >= 0) begin
      rend = (fmode == 3 && fcyc < rw) ? r + fcyc : r + rw;
      idle = rend + 1;
    end
    last = idle;
    if (busld && (b + dd + 1 > last)) last = b + dd + 1;
    t_a = a; t_b = b; t_r = r; t_rend = rend; t_idle = idle;
    t_bus = busld; t_rsp = (r >= 0);
    t_waddr = {addr[31:2], 2'b00};
    t_pay = {edata, addr[1:0], typ, rd, (cause != 2'd0), cause};
    obs_rsp_first = -1;
    obs_mread_seen = 1'b0;
    obs_addr = '0;
    obs_pay = '0;
    d_req_valid = 1'b1;
    d_req_addr = addr;
    d_req_type = typ;
    d_req_rd = rd;
    d_flush = 1'b0;
    d_waitreq = 1'b0;
    d_rdv = 1'b0;
    d_rsp_ready = 1'b0;
    for (int c = a + 1; c <= last; c++) begin
      @(posedge clk); #1;
      d_req_valid = 1'b0;
      d_req_addr  = $urandom;
      d_req_type  = 3'($urandom);
      d_req_rd    = 5'($urandom);
      if (busld && c <= a + ws) d_waitreq = 1'b1;
      else if (busld && c <= b) d_waitreq = 1'b0;
      else d_waitreq = 1'($urandom);
      d_rdv   = busld && (c == b + dd);
      d_rdata = d_rdv ? data : $urandom;
      d_resp  = d_rdv ? resp : 2'($urandom);
      d_flush = ((fmode == 1) && (c == a + 1 + fcyc)) ||
                ((fmode == 2) && (c == b + 1 + fcyc)) ||
                ((fmode == 3) && (c == r + fcyc));
      if (r >= 0 && c >= r) d_rsp_ready = (c >= r + rw);
      else d_rsp_ready = 1'($urandom);
    end
    d_flush = 1'b0;
    d_rdv = 1'b0;
    d_waitreq = 1'b0;
    d_rsp_ready = 1'b0;
  endtask

  task automatic rand_load();
    logic [2:0] typ;
    int ws, dd, rw, fm, fc, to;
    to  = sel4 ? 4 : 255;
    typ = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
          (($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 1) * 4 + 1));
    ws  = $urandom_range(0, 3);
    dd  = sel4 ? $urandom_range(1, 7) : $urandom_range(1, 6);
    rw  = $urandom_range(0, 3);
    fm  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    fc  = 0;
    if (fm == 1) fc = $urandom_range(0, ws);
    if (fm == 2) begin
      if (dd >= 2 && dd <= to) fc = $urandom_range(0, dd - 2);
      else fm = 0;
    end
    if (fm == 3) fc = $urandom_range(0, rw);
    run_load($urandom, typ, 5'($urandom), ws, dd, $urandom,
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0, rw, fm, fc);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    sel4 = 1'b0;
    chk_en = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_type = '0; d_req_rd = '0;
    d_flush = 1'b0; d_waitreq = 1'b0; d_rdv = 1'b0; d_rdata = '0; d_resp = '0;
    d_rsp_ready = 1'b0;
    clear_model();
    obs_rsp_first = -1;
    obs_mread_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_read", 64'(o_m_read), 64'd0);
    chk("rst_m_address", 64'(o_m_address), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_payload", 64'(o_pay), 64'd0);
    chk("rst_req_ready", 64'(o_req_ready), 64'd1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Word load, zero-wait slave.
    run_load(32'h0000_1004, 3'd2, 5'd5, 0, 1, 32'hDEAD_BEEF, 2'd0, 0, 0, 0);
    chk("lit_word_latency", 64'(obs_rsp_first - t_a), 64'd3);
    chk("lit_word_addr", 64'(obs_addr), 64'h0000_1004);
    chk("lit_word_pay", 64'(obs_pay), 64'({32'hDEAD_BEEF, 2'd0, 3'd2, 5'd5, 1'b0, 2'd0}));

    // Misaligned half and unknown type: no bus traffic.
    run_load(32'h0000_0103, 3'd1, 5'd7, 0, 1, 32'h0, 2'd0, 0, 0, 0);
    chk("lit_mis_latency", 64'(obs_rsp_first - t_a), 64'd1);
    chk("lit_mis_noread", 64'(obs_mread_seen), 64'd0);
    chk("lit_mis_pay", 64'(obs_pay), 64'({32'h0, 2'd3, 3'd1, 5'd7, 1'b1, 2'd1}));
    run_load(32'h0000_0100, 3'd3, 5'd8, 0, 1, 32'h0, 2'd0, 0, 0, 0);
    chk("lit_unk_noread", 64'(obs_mread_seen), 64'd0);
    chk("lit_unk_pay", 64'(obs_pay), 64'({32'h0, 2'd0, 3'd3, 5'd8, 1'b1, 2'd2}));

    // Unsigned byte with stalls, slow data and a slow consumer.
    run_load(32'h0000_2003, 3'd4, 5'd9, 3, 5, 32'h1122_3344, 2'd0, 2, 0, 0);
    chk("lit_bu_addr", 64'(obs_addr), 64'h0000_2000);
    chk("lit_bu_latency", 64'(obs_rsp_first - t_a), 64'd10);
    chk("lit_bu_pay", 64'(obs_pay), 64'({32'h1122_3344, 2'd3, 3'd4, 5'd9, 1'b0, 2'd0}));

    // Error response from the slave.
    run_load(32'h0000_3000, 3'd2, 5'd1, 0, 1, 32'hCAFE_F00D, 2'd2, 0, 0, 0);
    chk("lit_err_pay", 64'(obs_pay), 64'({32'hCAFE_F00D, 2'd0, 3'd2, 5'd1, 1'b1, 2'd3}));

    // Flush in WAIT, data two cycles later is drained; then a normal load.
    run_load(32'h0000_5000, 3'd2, 5'd3, 0, 3, 32'h5555_AAAA, 2'd0, 0, 2, 0);
    chk("lit_drain_norsp", 64'(obs_rsp_first), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit_drain_idle", 64'(t_idle - t_a), 64'd5);
    run_load(32'h0000_6002, 3'd5, 5'd4, 0, 1, 32'hA5A5_5A5A, 2'd0, 0, 0, 0);
    chk("lit_after_pay", 64'(obs_pay), 64'({32'hA5A5_5A5A, 2'd2, 3'd5, 5'd4, 1'b0, 2'd0}));

    // Flush in IDLE drops a simultaneous request.
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_7000; d_req_type = 3'd2; d_flush = 1'b1;
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_flush = 1'b0;
    chk("lit_idle_flush_noread", 64'(o_m_read), 64'd0);
    chk("lit_idle_flush_ready", 64'(o_req_ready), 64'd1);

    for (int i = 0; i < 60; i++) rand_load();

    // Short-timeout instance: timeout with late data, then random traffic.
    sel4 = 1'b1;
    run_load(32'h0000_4000, 3'd2, 5'd2, 0, 20, 32'h7777_7777, 2'd0, 0, 0, 0);
    chk("lit_to_latency", 64'(obs_rsp_first - t_a), 64'd6);
    chk("lit_to_pay", 64'(obs_pay), 64'({32'h0, 2'd0, 3'd2, 5'd2, 1'b1, 2'd3}));
    for (int i = 0; i < 30; i++) rand_load();
    sel4 = 1'b0;

    // Asynchronous reset while the read is stalled in ISSUE.
    chk_en = 1'b0;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_0300; d_req_type = 3'd2; d_req_rd = 5'd6;
    d_waitreq = 1'b1;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    chk("lit_rst_issue_read", 64'(o_m_read), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_async_m_read", 64'(o_m_read), 64'd0);
    chk("lit_async_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("lit_async_ready", 64'(o_req_ready), 64'd1);
    @(posedge clk); #1;
    d_waitreq = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("lit_post_rst_ready", 64'(o_req_ready), 64'd1);
    clear_model();
    chk_en = 1'b1;
    run_load(32'h0000_0304, 3'd0, 5'd11, 1, 2, 32'h0BAD_F00D, 2'd0, 1, 0, 0);
    chk("lit_post_rst_pay", 64'(obs_pay), 64'({32'h0BAD_F00D, 2'd0, 3'd0, 5'd11, 1'b0, 2'd0}));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
